// File: rtl/test_scoreboard.sv
// Purpose: collects pass/fail check events from test blocks and raises done / all-pass / timeout verdicts.
// Latency: one cycle; each accepted check shows up in the counters on the edge after it is presented.
// Backpressure: none; one check per cycle is always consumed, and illegal reports set a sticky error.
module test_scoreboard #(
  parameter int N_TESTS = 16,
  parameter int ID_W    = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 10000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               check_valid,
  input  logic [ID_W-1:0]    check_id,
  input  logic               check_pass,
  input  logic [N_TESTS-1:0] test_done,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic [ID_W-1:0]    first_fail_id,
  output logic               first_fail_valid,
  output logic               protocol_err,
  output logic               all_done,
  output logic               all_pass,
  output logic               timed_out,
  output logic [31:0]        cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [31:0]      CYC_MAX   = 32'hFFFF_FFFF;
  localparam logic [31:0]      CYC_LIMIT = 32'(TIMEOUT - 1);

  state_t state;
  state_t state_nxt;

  // Remembers every test that has ever reported done; a falling test_done bit
  // must not re-arm its test, and a check arriving on the same cycle that its
  // test_done bit first rises is still legal.
  logic [N_TESTS-1:0] done_seen;

  logic             id_in_range;
  logic             id_seen;
  logic             is_run;
  logic             chk_bad;
  logic             chk_ok;
  logic             all_td;
  logic [CNT_W-1:0] pass_nxt;
  logic [CNT_W-1:0] fail_nxt;
  logic             perr_nxt;
  logic             ff_capture;
  logic             all_pass_nxt;

  // Classify the presented check and work out next counter, flag and state values.
  always_comb begin
    id_in_range  = 32'(check_id) < 32'(N_TESTS);
    id_seen      = id_in_range ? done_seen[check_id] : 1'b0;
    is_run       = (state == ST_RUN);
    chk_bad      = check_valid && (!id_in_range || id_seen || !is_run);
    chk_ok       = check_valid && !chk_bad;
    all_td       = &test_done;

    pass_nxt = pass_count;
    fail_nxt = fail_count;
    if (chk_ok && check_pass && (pass_count != CNT_MAX)) begin
      pass_nxt = pass_count + 1'b1;
    end
    if (chk_ok && !check_pass && (fail_count != CNT_MAX)) begin
      fail_nxt = fail_count + 1'b1;
    end

    perr_nxt   = protocol_err | chk_bad;
    ff_capture = chk_ok && !check_pass && !first_fail_valid;

    // Completion beats timeout when both happen on the same cycle.
    state_nxt = state;
    if (is_run) begin
      if (all_td) begin
        state_nxt = ST_DONE;
      end else if (cycle_count >= CYC_LIMIT) begin
        state_nxt = ST_TIMEOUT;
      end
    end

    // Re-evaluated every cycle in DONE so a late protocol error clears it.
    all_pass_nxt = (state_nxt == ST_DONE) && (fail_nxt == '0) && !perr_nxt;
  end

  // Register state, tallies, first-failure capture and verdict outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_RUN;
      done_seen        <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_id    <= '0;
      first_fail_valid <= 1'b0;
      protocol_err     <= 1'b0;
      all_done         <= 1'b0;
      all_pass         <= 1'b0;
      timed_out        <= 1'b0;
      cycle_count      <= '0;
    end else begin
      state        <= state_nxt;
      done_seen    <= done_seen | test_done;
      pass_count   <= pass_nxt;
      fail_count   <= fail_nxt;
      protocol_err <= perr_nxt;
      if (ff_capture) begin
        first_fail_id    <= check_id;
        first_fail_valid <= 1'b1;
      end
      if (is_run && (cycle_count != CYC_MAX)) begin
        cycle_count <= cycle_count + 32'd1;
      end
      all_done  <= (state_nxt != ST_RUN);
      timed_out <= (state_nxt == ST_TIMEOUT);
      all_pass  <= all_pass_nxt;
    end
  end

endmodule

// File: tb/tb_test_scoreboard.sv
// Purpose: checks test_scoreboard against a cycle-level reference model using directed and random stimulus.
// Latency: inputs change 1ns after each rising edge; outputs are compared 1ns after the next edge.
// Backpressure: not applicable; the design always accepts, so the bench drives one event per cycle.
module tb_test_scoreboard;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int CW = 3;
  localparam int TO = 20;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          check_valid;
  logic [IW-1:0] check_id;
  logic          check_pass;
  logic [N-1:0]  test_done;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] fail_count;
  logic [IW-1:0] first_fail_id;
  logic          first_fail_valid;
  logic          protocol_err;
  logic          all_done;
  logic          all_pass;
  logic          timed_out;
  logic [31:0]   cycle_count;

  test_scoreboard #(
    .N_TESTS(N), .ID_W(IW), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .check_valid(check_valid), .check_id(check_id),
    .check_pass(check_pass), .test_done(test_done), .pass_count(pass_count),
    .fail_count(fail_count), .first_fail_id(first_fail_id),
    .first_fail_valid(first_fail_valid), .protocol_err(protocol_err),
    .all_done(all_done), .all_pass(all_pass), .timed_out(timed_out),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = running, 1 = finished, 2 = timed out.
  int          m_phase;
  int          m_pass;
  int          m_fail;
  int          m_ffid;
  int          m_ffv;
  int          m_perr;
  int unsigned m_cyc;
  bit [N-1:0]  m_finished;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one clock edge's worth of the scoreboard rules to the model.
  task automatic model_edge();
    int  idx;
    bit  running;
    if (reset) begin
      m_phase = 0; m_pass = 0; m_fail = 0; m_ffid = 0; m_ffv = 0; m_perr = 0;
      m_cyc = 0; m_finished = '0;
    end else begin
      running = (m_phase == 0);
      idx = int'(check_id);
      if (check_valid) begin
        if (idx >= N || m_finished[idx] || !running) begin
          m_perr = 1;
        end else if (check_pass) begin
          m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
        end else begin
          m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
          if (m_ffv == 0) begin
            m_ffv = 1;
            m_ffid = idx;
          end
        end
      end
      if (running) begin
        if (test_done == {N{1'b1}}) m_phase = 1;
        else if (m_cyc >= TO - 1) m_phase = 2;
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
      end
      m_finished = m_finished | test_done;
    end
  endtask

  task automatic compare_all();
    check_eq("pass_count", 32'(pass_count), 32'(m_pass));
    check_eq("fail_count", 32'(fail_count), 32'(m_fail));
    check_eq("first_fail_id", 32'(first_fail_id), 32'(m_ffid));
    check_eq("first_fail_valid", 32'(first_fail_valid), 32'(m_ffv));
    check_eq("protocol_err", 32'(protocol_err), 32'(m_perr));
    check_eq("all_done", 32'(all_done), 32'(m_phase != 0));
    check_eq("timed_out", 32'(timed_out), 32'(m_phase == 2));
    check_eq("all_pass", 32'(all_pass), 32'(m_phase == 1 && m_fail == 0 && m_perr == 0));
    check_eq("cycle_count", cycle_count, m_cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; check_valid = 1'b0; test_done = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input int id, input bit p);
    check_valid = 1'b1; check_id = IW'(id); check_pass = p;
    tick();
    check_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; check_valid = 1'b0; check_id = '0; check_pass = 1'b0; test_done = '0;
    m_phase = 0; m_pass = 0; m_fail = 0; m_ffid = 0; m_ffv = 0; m_perr = 0;
    m_cyc = 0; m_finished = '0;
    #2;

    // 1: five passes then everything done
    do_reset();
    check_eq("rst_pass_count", 32'(pass_count), 32'd0);
    check_eq("rst_all_done", 32'(all_done), 32'd0);
    check_eq("rst_cycle_count", cycle_count, 32'd0);
    for (int i = 0; i < 5; i++) send(i, 1'b1);
    test_done = '1;
    tick();
    check_eq("t1_pass_count", 32'(pass_count), 32'd5);
    check_eq("t1_fail_count", 32'(fail_count), 32'd0);
    check_eq("t1_all_done", 32'(all_done), 32'd1);
    check_eq("t1_all_pass", 32'(all_pass), 32'd1);
    check_eq("t1_timed_out", 32'(timed_out), 32'd0);

    // 2: two failures, first one captured
    do_reset();
    send(7, 1'b0);
    send(3, 1'b0);
    send(7, 1'b1);
    test_done = '1;
    tick();
    check_eq("t2_fail_count", 32'(fail_count), 32'd2);
    check_eq("t2_pass_count", 32'(pass_count), 32'd1);
    check_eq("t2_first_fail_id", 32'(first_fail_id), 32'd7);
    check_eq("t2_first_fail_valid", 32'(first_fail_valid), 32'd1);
    check_eq("t2_all_pass", 32'(all_pass), 32'd0);
    check_eq("t2_all_done", 32'(all_done), 32'd1);

    // 3: timeout after exactly TO run cycles
    do_reset();
    test_done = 16'h7FFF;
    for (int i = 0; i < TO - 1; i++) tick();
    check_eq("t3_timed_out_early", 32'(timed_out), 32'd0);
    tick();
    check_eq("t3_timed_out", 32'(timed_out), 32'd1);
    check_eq("t3_all_done", 32'(all_done), 32'd1);
    check_eq("t3_cycle_count", cycle_count, 32'd20);
    check_eq("t3_all_pass", 32'(all_pass), 32'd0);
    tick();
    check_eq("t3_cycle_frozen", cycle_count, 32'd20);

    // 4: check from a finished test, and a check after DONE
    do_reset();
    test_done = 16'h0004;
    tick();
    send(2, 1'b1);
    check_eq("t4_perr_done_test", 32'(protocol_err), 32'd1);
    test_done = '1;
    tick();
    send(0, 1'b1);
    check_eq("t4_protocol_err", 32'(protocol_err), 32'd1);
    check_eq("t4_pass_count", 32'(pass_count), 32'd0);
    check_eq("t4_fail_count", 32'(fail_count), 32'd0);
    check_eq("t4_all_pass", 32'(all_pass), 32'd0);
    check_eq("t4_all_done", 32'(all_done), 32'd1);

    // 5: saturation, then reset mid-stream
    do_reset();
    for (int i = 0; i < 9; i++) send(i, 1'b1);
    check_eq("t5_pass_sat", 32'(pass_count), 32'd7);
    reset = 1'b1; check_valid = 1'b1; check_id = 4'd9; check_pass = 1'b0;
    tick();
    reset = 1'b0; check_valid = 1'b0;
    check_eq("t5_rst_pass", 32'(pass_count), 32'd0);
    check_eq("t5_rst_fail", 32'(fail_count), 32'd0);
    check_eq("t5_rst_ffv", 32'(first_fail_valid), 32'd0);
    check_eq("t5_rst_cycle", cycle_count, 32'd0);

    // 6: failing check on the completion cycle is accepted
    do_reset();
    test_done = '1;
    send(1, 1'b0);
    check_eq("t6_fail_count", 32'(fail_count), 32'd1);
    check_eq("t6_first_fail_id", 32'(first_fail_id), 32'd1);
    check_eq("t6_all_done", 32'(all_done), 32'd1);
    check_eq("t6_timed_out", 32'(timed_out), 32'd0);
    check_eq("t6_all_pass", 32'(all_pass), 32'd0);
    check_eq("t6_protocol_err", 32'(protocol_err), 32'd0);

    // Random runs against the model
    for (int run = 0; run < 30; run++) begin
      do_reset();
      for (int c = 0; c < 35; c++) begin
        int r;
        check_valid = 1'($urandom % 2);
        check_id    = IW'($urandom % N);
        check_pass  = ($urandom % 4) != 0;
        r = int'($urandom % 16);
        if (r == 0) test_done = '1;
        else if (r < 8) test_done[$urandom % N] = 1'b1;
        else if (r == 8) test_done[$urandom % N] = 1'b0;
        reset = ($urandom % 64) == 0;
        tick();
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
